// File: rtl/instruction_encode_pkg.sv
// ControlTypeDefs: instruction classes and operations shared by the decode and
// encode sides, plus the RV32I opcode constants used by the encoder and the
// NOP word that fills the output when nothing (or nothing legal) is available.
package ControlTypeDefs;

  typedef enum logic [2:0] {
    R_TYPE, I_TYPE, LOAD_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } InstructionTypes;

  typedef enum logic [4:0] {
    NULL, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LUI, AUIPC, JUMP_LINK, JUMP_LINK_REG
  } InstructionSubTypes;

  typedef enum logic {IDLE, SECOND} EncodeStates;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // funct3 for every operation; the class decides which opcode it goes with.
  function automatic logic [2:0] funct3Of(input InstructionSubTypes sub);
    logic [2:0] f3;
    f3 = 3'b000;
    case (sub)
      SLL, LH, SH, BNE:   f3 = 3'b001;
      SLT, LW, SW:        f3 = 3'b010;
      SLTU:               f3 = 3'b011;
      XOR, LBU, BLT:      f3 = 3'b100;
      SRL, SRA, LHU, BGE: f3 = 3'b101;
      OR, BLTU:           f3 = 3'b110;
      AND, BGEU:          f3 = 3'b111;
      default:            f3 = 3'b000;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// instruction_fifo: output word buffer between the encoder and its consumer.
//   iClk/iRst     clock and synchronous active-high reset
//   push/pushWord write one word (ignored when full)
//   pop           remove the head word (ignored when empty)
//   headValid     buffer not empty
//   headWord      oldest stored word, NOP when empty
//   count         occupancy, 0..DEPTH
module instruction_fifo
  import ControlTypeDefs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     push,
  input  logic [31:0]              pushWord,
  input  logic                     pop,
  output logic                     headValid,
  output logic [31:0]              headWord,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  // Guards so a full buffer is never overwritten and an empty one never read.
  assign doPop  = pop && (count != '0);
  assign doPush = push && (count != FULL_COUNT);

  // Pointers are exactly PW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the empty check hides stale contents.
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr] <= pushWord;
  end

  assign headValid = (count != '0);
  assign headWord  = headValid ? mem[rdPtr] : NOP_WORD;

endmodule

// File: rtl/instruction_encode.sv
// instruction_encode: turns instruction requests into RV32I machine words and
// queues them for a consumer. Load-immediate values that do not fit 12 bits
// become LUI followed by ADDI, the ADDI issued from the SECOND state.
//   iClk, iRst                         clock, synchronous active-high reset
//   iValid/iReady                      request handshake
//   iInstructionType/SubType           class and operation
//   iRd, iRs1, iRs2, iImm, iPseudoLi   operands
//   oValid/oReady, oInstruction        output word handshake
//   oCount                             buffered words
//   oError                             sticky: an illegal request was seen
module instruction_encode
  import ControlTypeDefs::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iValid,
  output logic                          iReady,
  input  InstructionTypes               iInstructionType,
  input  InstructionSubTypes            iInstructionSubType,
  input  logic [4:0]                    iRd,
  input  logic [4:0]                    iRs1,
  input  logic [4:0]                    iRs2,
  input  logic [31:0]                   iImm,
  input  logic                          iPseudoLi,
  output logic                          oValid,
  input  logic                          oReady,
  output logic [31:0]                   oInstruction,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic                          oError
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = FIFO_DEPTH[CW-1:0];

  EncodeStates state;
  logic [4:0]  pendRd;
  logic [11:0] pendImm;

  logic        notFull;
  logic        accept;
  logic        pushEn;
  logic [31:0] pushWord;
  logic [31:0] encWord;
  logic        encBad;
  logic        liSplit;
  logic [2:0]  f3;
  logic        fits12;
  logic        fitsBranch;
  logic        fitsJal;
  logic [19:0] liUpper;
  logic [6:0]  shiftF7;

  assign notFull = (oCount < FULL_COUNT);
  // Gated by iRst so nothing is taken during the reset cycle itself.
  assign iReady  = !iRst && (state == IDLE) && notFull;
  assign accept  = iValid && iReady;

  // Range checks as sign-extension tests on the upper immediate bits.
  assign fits12     = (&iImm[31:11]) || !(|iImm[31:11]);
  assign fitsBranch = ((&iImm[31:12]) || !(|iImm[31:12])) && !iImm[0];
  assign fitsJal    = ((&iImm[31:20]) || !(|iImm[31:20])) && !iImm[0];
  // (iImm + 0x800) >> 12 rounds so the signed low 12 bits of ADDI land back on iImm.
  assign liUpper    = iImm[31:12] + {19'd0, iImm[11]};
  assign f3         = funct3Of(iInstructionSubType);
  assign shiftF7    = (iInstructionSubType == SRA || iInstructionSubType == SUB) ? 7'b0100000 : 7'b0000000;

  // Encodes the presented request; an operation that does not belong to the
  // class, or an operand out of range, marks the request illegal.
  always_comb begin
    encWord = NOP_WORD;
    encBad  = 1'b0;
    liSplit = 1'b0;
    if (iPseudoLi) begin
      if (fits12) begin
        encWord = {iImm[11:0], 5'd0, 3'b000, iRd, OPCODE_OP_IMM};
      end else begin
        encWord = {liUpper, iRd, OPCODE_LUI};
        liSplit = 1'b1;
      end
    end else begin
      unique case (iInstructionType)
        R_TYPE: begin
          encBad  = !(iInstructionSubType inside {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND});
          encWord = {shiftF7, iRs2, iRs1, f3, iRd, OPCODE_OP};
        end
        I_TYPE: begin
          if (iInstructionSubType inside {SLL, SRL, SRA}) begin
            encBad  = |iImm[31:5];
            encWord = {shiftF7, iImm[4:0], iRs1, f3, iRd, OPCODE_OP_IMM};
          end else begin
            encBad  = !(iInstructionSubType inside {ADD, SLT, SLTU, XOR, OR, AND}) || !fits12;
            encWord = {iImm[11:0], iRs1, f3, iRd, OPCODE_OP_IMM};
          end
        end
        LOAD_TYPE: begin
          encBad  = !(iInstructionSubType inside {LB, LH, LW, LBU, LHU}) || !fits12;
          encWord = {iImm[11:0], iRs1, f3, iRd, OPCODE_LOAD};
        end
        S_TYPE: begin
          encBad  = !(iInstructionSubType inside {SB, SH, SW}) || !fits12;
          encWord = {iImm[11:5], iRs2, iRs1, f3, iImm[4:0], OPCODE_STORE};
        end
        B_TYPE: begin
          encBad  = !(iInstructionSubType inside {BEQ, BNE, BLT, BGE, BLTU, BGEU}) || !fitsBranch;
          encWord = {iImm[12], iImm[10:5], iRs2, iRs1, f3, iImm[4:1], iImm[11], OPCODE_BRANCH};
        end
        U_TYPE: begin
          encBad  = !(iInstructionSubType inside {LUI, AUIPC}) || (|iImm[11:0]);
          encWord = {iImm[31:12], iRd, (iInstructionSubType == AUIPC) ? OPCODE_AUIPC : OPCODE_LUI};
        end
        J_TYPE: begin
          if (iInstructionSubType == JUMP_LINK) begin
            encBad  = !fitsJal;
            encWord = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, OPCODE_JAL};
          end else begin
            encBad  = (iInstructionSubType != JUMP_LINK_REG) || !fits12;
            encWord = {iImm[11:0], iRs1, 3'b000, iRd, OPCODE_JALR};
          end
        end
        default: encBad = 1'b1;
      endcase
    end
  end

  // In SECOND the buffer input is reserved for the deferred ADDI.
  always_comb begin
    pushEn   = accept;
    pushWord = encBad ? NOP_WORD : encWord;
    if (state == SECOND) begin
      pushEn   = notFull;
      pushWord = {pendImm, pendRd, 3'b000, pendRd, OPCODE_OP_IMM};
    end
  end

  // Two-state sequencer for split load-immediates plus the sticky error flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      pendRd  <= '0;
      pendImm <= '0;
      oError  <= 1'b0;
    end else if (state == SECOND) begin
      if (notFull) state <= IDLE;
    end else if (accept) begin
      if (encBad) oError <= 1'b1;
      if (liSplit) begin
        state   <= SECOND;
        pendRd  <= iRd;
        pendImm <= iImm[11:0];
      end
    end
  end

  instruction_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .iClk      (iClk),
    .iRst      (iRst),
    .push      (pushEn),
    .pushWord  (pushWord),
    .pop       (oReady),
    .headValid (oValid),
    .headWord  (oInstruction),
    .count     (oCount)
  );

endmodule

// File: tb/tb_instruction_encode.sv
// Bench for instruction_encode: directed cases with known RV32I words plus a
// randomized run checked every cycle against a queue-level reference model.
module tb_instruction_encode;
  import ControlTypeDefs::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic iClk = 1'b0;
  logic iRst, iValid, iReady, iPseudoLi, oValid, oReady, oError;
  InstructionTypes    iInstructionType;
  InstructionSubTypes iInstructionSubType;
  logic [4:0]  iRd, iRs1, iRs2;
  logic [31:0] iImm, oInstruction;
  logic [$clog2(DEPTH):0] oCount;

  int checks = 0;
  int failures = 0;

  logic [31:0] expQ[$];
  bit          pending = 1'b0;
  logic [31:0] pendWord = NOP;
  bit          modelErr = 1'b0;

  always #5 iClk = ~iClk;

  instruction_encode #(.FIFO_DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iReady(iReady),
    .iInstructionType(iInstructionType), .iInstructionSubType(iInstructionSubType),
    .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm), .iPseudoLi(iPseudoLi),
    .oValid(oValid), .oReady(oReady), .oInstruction(oInstruction),
    .oCount(oCount), .oError(oError)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Places the low 'width' bits of v at bit position lsb.
  function automatic logic [31:0] fld(input longint v, input int lsb, input int width);
    longint m;
    m = v & ((longint'(1) << width) - 1);
    return 32'(m << lsb);
  endfunction

  function automatic int f3Ref(input InstructionSubTypes s);
    case (s)
      SLL, LH, SH, BNE:   return 1;
      SLT, LW, SW:        return 2;
      SLTU:               return 3;
      XOR, LBU, BLT:      return 4;
      SRL, SRA, LHU, BGE: return 5;
      OR, BLTU:           return 6;
      AND, BGEU:          return 7;
      default:            return 0;
    endcase
  endfunction

  // Reference encoder working from integer ranges and field arithmetic.
  function automatic void modelEncode(input InstructionTypes t, input InstructionSubTypes s,
                                      input int rd, input int rs1, input int rs2, input int imm, input bit li,
                                      output logic [31:0] first, output bit split,
                                      output logic [31:0] second, output bit bad);
    int f3;
    longint hi;
    f3 = f3Ref(s);
    bad = 1'b0; split = 1'b0; second = NOP; first = NOP;
    if (li) begin
      if (imm >= -2048 && imm <= 2047) first = fld(imm, 20, 12) + fld(rd, 7, 5) + 32'h13;
      else begin
        hi = (longint'(imm) + 2048) >>> 12;
        first  = fld(hi, 12, 20) + fld(rd, 7, 5) + 32'h37;
        second = fld(imm, 20, 12) + fld(rd, 15, 5) + fld(rd, 7, 5) + 32'h13;
        split  = 1'b1;
      end
      return;
    end
    case (t)
      R_TYPE: begin
        bad = !(s inside {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND});
        first = fld((s == SUB || s == SRA) ? 32 : 0, 25, 7) + fld(rs2, 20, 5) + fld(rs1, 15, 5)
              + fld(f3, 12, 3) + fld(rd, 7, 5) + 32'h33;
      end
      I_TYPE: begin
        if (s inside {SLL, SRL, SRA}) begin
          bad = (imm < 0 || imm > 31);
          first = fld(s == SRA ? 32 : 0, 25, 7) + fld(imm, 20, 5) + fld(rs1, 15, 5) + fld(f3, 12, 3) + fld(rd, 7, 5) + 32'h13;
        end else begin
          bad = !(s inside {ADD, SLT, SLTU, XOR, OR, AND}) || imm < -2048 || imm > 2047;
          first = fld(imm, 20, 12) + fld(rs1, 15, 5) + fld(f3, 12, 3) + fld(rd, 7, 5) + 32'h13;
        end
      end
      LOAD_TYPE: begin
        bad = !(s inside {LB, LH, LW, LBU, LHU}) || imm < -2048 || imm > 2047;
        first = fld(imm, 20, 12) + fld(rs1, 15, 5) + fld(f3, 12, 3) + fld(rd, 7, 5) + 32'h03;
      end
      S_TYPE: begin
        bad = !(s inside {SB, SH, SW}) || imm < -2048 || imm > 2047;
        first = fld(imm >>> 5, 25, 7) + fld(rs2, 20, 5) + fld(rs1, 15, 5) + fld(f3, 12, 3) + fld(imm, 7, 5) + 32'h23;
      end
      B_TYPE: begin
        bad = !(s inside {BEQ, BNE, BLT, BGE, BLTU, BGEU}) || (imm % 2 != 0) || imm < -4096 || imm > 4094;
        first = fld(imm >>> 12, 31, 1) + fld(imm >>> 5, 25, 6) + fld(rs2, 20, 5) + fld(rs1, 15, 5)
              + fld(f3, 12, 3) + fld(imm >>> 1, 8, 4) + fld(imm >>> 11, 7, 1) + 32'h63;
      end
      U_TYPE: begin
        bad = !(s inside {LUI, AUIPC}) || ((imm & 'hFFF) != 0);
        first = fld(imm >>> 12, 12, 20) + fld(rd, 7, 5) + (s == AUIPC ? 32'h17 : 32'h37);
      end
      J_TYPE: begin
        if (s == JUMP_LINK) begin
          bad = (imm % 2 != 0) || imm < -1048576 || imm > 1048574;
          first = fld(imm >>> 20, 31, 1) + fld(imm >>> 1, 21, 10) + fld(imm >>> 11, 20, 1)
                + fld(imm >>> 12, 12, 8) + fld(rd, 7, 5) + 32'h6F;
        end else begin
          bad = (s != JUMP_LINK_REG) || imm < -2048 || imm > 2047;
          first = fld(imm, 20, 12) + fld(rs1, 15, 5) + fld(rd, 7, 5) + 32'h67;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) first = NOP;
  endfunction

  // One clock: compare every output with the model, then advance the model
  // by the accept/pop events of this cycle and move to the next falling edge.
  task automatic stepCycle();
    logic [31:0] w0, w1, head;
    bit sp, bd, acc, pop, mReady;
    int sz;
    #1;
    sz = expQ.size();
    mReady = !iRst && !pending && sz < DEPTH;
    head = (sz != 0) ? expQ[0] : NOP;
    checkOutput("iReady", 32'(iReady), 32'(mReady));
    checkOutput("oValid", 32'(oValid), 32'(sz != 0));
    checkOutput("oCount", 32'(oCount), 32'(sz));
    checkOutput("oInstruction", oInstruction, head);
    checkOutput("oError", 32'(oError), 32'(modelErr));
    if (iRst) begin
      expQ.delete();
      pending = 1'b0;
      modelErr = 1'b0;
    end else begin
      pop = (sz != 0) && oReady;
      acc = iValid && mReady;
      if (pop) void'(expQ.pop_front());
      if (pending) begin
        if (sz < DEPTH) begin
          expQ.push_back(pendWord);
          pending = 1'b0;
        end
      end else if (acc) begin
        modelEncode(iInstructionType, iInstructionSubType, int'(iRd), int'(iRs1), int'(iRs2),
                    int'(iImm), iPseudoLi, w0, sp, w1, bd);
        expQ.push_back(w0);
        if (bd) modelErr = 1'b1;
        if (sp) begin
          pending = 1'b1;
          pendWord = w1;
        end
      end
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  // Presents one request and holds it until taken (bounded).
  task automatic applyStimulus(input InstructionTypes t, input InstructionSubTypes s, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input bit li);
    bit taken;
    taken = 1'b0;
    iValid = 1'b1; iInstructionType = t; iInstructionSubType = s;
    iRd = rd; iRs1 = rs1; iRs2 = rs2; iImm = imm; iPseudoLi = li;
    for (int n = 0; n < 20 && !taken; n++) begin
      taken = iReady;
      stepCycle();
    end
    if (!taken) checkOutput("acceptTimeout", 32'd0, 32'd1);
    iValid = 1'b0;
    iPseudoLi = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    iValid = 1'b0;
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  task automatic resetPulse();
    iRst = 1'b1;
    stepCycle();
    iRst = 1'b0;
  endtask

  InstructionSubTypes subList[7][10] = '{
    '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND},
    '{ADD, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, SUB},
    '{LB, LH, LW, LBU, LHU, LB, LH, LW, LBU, LHU},
    '{SB, SH, SW, SB, SH, SW, SB, SH, SW, SW},
    '{BEQ, BNE, BLT, BGE, BLTU, BGEU, BEQ, BNE, BLT, BGE},
    '{LUI, AUIPC, LUI, AUIPC, LUI, AUIPC, LUI, AUIPC, LUI, AUIPC},
    '{JUMP_LINK, JUMP_LINK_REG, JUMP_LINK, JUMP_LINK_REG, JUMP_LINK, JUMP_LINK_REG, JUMP_LINK, JUMP_LINK_REG, JUMP_LINK, JUMP_LINK_REG}
  };

  initial begin
    int t;
    iRst = 1'b1; iValid = 1'b0; oReady = 1'b0; iPseudoLi = 1'b0;
    iInstructionType = R_TYPE; iInstructionSubType = NULL;
    iRd = '0; iRs1 = '0; iRs2 = '0; iImm = '0;
    @(negedge iClk);
    @(negedge iClk);

    // Reset state, and readiness right after reset is released.
    checkOutput("resetOValid", 32'(oValid), 32'd0);
    checkOutput("resetOCount", 32'(oCount), 32'd0);
    checkOutput("resetNop", oInstruction, NOP);
    checkOutput("resetReadyLow", 32'(iReady), 32'd0);
    stepCycle();
    iRst = 1'b0;
    #1 checkOutput("readyAfterReset", 32'(iReady), 32'd1);

    // ADD x3,x1,x2
    applyStimulus(R_TYPE, ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    checkOutput("addWord", oInstruction, 32'h002081B3);
    checkOutput("addCount", 32'(oCount), 32'd1);
    oReady = 1'b1;
    idleCycles(2);

    // SW x2,-4(x1)
    applyStimulus(S_TYPE, SW, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    checkOutput("swWord", oInstruction, 32'hFE20AE23);
    idleCycles(1);

    // Split load-immediates and a short one.
    applyStimulus(R_TYPE, NULL, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1);
    checkOutput("liLui", oInstruction, 32'h123452B7);
    checkOutput("liReadyLow", 32'(iReady), 32'd0);
    stepCycle();
    checkOutput("liAddi", oInstruction, 32'h67828293);
    checkOutput("liReadyBack", 32'(iReady), 32'd1);
    idleCycles(2);
    applyStimulus(R_TYPE, NULL, 5'd5, 5'd0, 5'd0, 32'h00000FFF, 1'b1);
    checkOutput("liFffLui", oInstruction, 32'h000012B7);
    stepCycle();
    checkOutput("liFffAddi", oInstruction, 32'hFFF28293);
    idleCycles(2);
    applyStimulus(R_TYPE, NULL, 5'd7, 5'd0, 5'd0, 32'hFFFFFFFB, 1'b1);
    checkOutput("liShort", oInstruction, 32'hFFB00393);
    idleCycles(2);

    // Odd branch offset is illegal; error stays through later legal requests.
    applyStimulus(B_TYPE, BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    checkOutput("beqNop", oInstruction, NOP);
    checkOutput("beqError", 32'(oError), 32'd1);
    for (int k = 0; k < 10; k++) applyStimulus(R_TYPE, ADD, 5'(k + 1), 5'd1, 5'd2, 32'd0, 1'b0);
    checkOutput("errorSticky", 32'(oError), 32'd1);
    idleCycles(3);
    resetPulse();
    #1 checkOutput("errorCleared", 32'(oError), 32'd0);

    // Fill with the consumer stalled, hold a fifth request, then drain.
    oReady = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(R_TYPE, ADD, 5'(k), 5'd1, 5'd2, 32'd0, 1'b0);
    checkOutput("fullCount", 32'(oCount), 32'd4);
    checkOutput("fullReady", 32'(iReady), 32'd0);
    iValid = 1'b1; iRd = 5'd10;
    stepCycle();
    stepCycle();
    checkOutput("heldCount", 32'(oCount), 32'd4);
    checkOutput("heldHead", oInstruction, 32'h00208033 | (32'd1 << 7));
    oReady = 1'b1;
    stepCycle();
    checkOutput("afterFirstPopReady", 32'(iReady), 32'd1);
    checkOutput("afterFirstPopHead", oInstruction, 32'h00208033 | (32'd2 << 7));
    stepCycle();
    iValid = 1'b0;
    checkOutput("fifthAcceptedCount", 32'(oCount), 32'd3);
    idleCycles(4);
    checkOutput("drainedCount", 32'(oCount), 32'd0);

    // Reset while the deferred ADDI is waiting for space.
    oReady = 1'b0;
    for (int k = 1; k <= 3; k++) applyStimulus(R_TYPE, ADD, 5'(k), 5'd1, 5'd2, 32'd0, 1'b0);
    applyStimulus(R_TYPE, NULL, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1);
    idleCycles(2);
    checkOutput("secondStuckReady", 32'(iReady), 32'd0);
    checkOutput("secondStuckCount", 32'(oCount), 32'd4);
    resetPulse();
    #1;
    checkOutput("rstSecondValid", 32'(oValid), 32'd0);
    checkOutput("rstSecondCount", 32'(oCount), 32'd0);
    checkOutput("rstSecondReady", 32'(iReady), 32'd1);
    oReady = 1'b1;
    idleCycles(5);
    checkOutput("noLateAddi", 32'(oValid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      iRst   = ($urandom_range(0, 99) == 0);
      oReady = ($urandom_range(0, 3) != 0);
      iValid = ($urandom_range(0, 2) != 0);
      t = $urandom_range(0, 6);
      iInstructionType = InstructionTypes'(t);
      iInstructionSubType = ($urandom_range(0, 15) == 0) ? NULL : subList[t][$urandom_range(0, 9)];
      iRd = 5'($urandom); iRs1 = 5'($urandom); iRs2 = 5'($urandom);
      iPseudoLi = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0: iImm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: iImm = 32'($urandom_range(0, 40));
        2: iImm = $urandom();
        3: iImm = $urandom() & 32'hFFFFF000;
        default: iImm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      stepCycle();
    end
    iRst = 1'b0;
    idleCycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/instruction_encode.md
INSTRUCTION_ENCODE -- requirements
Module: instruction_encode

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer depth in words (power of two, ≥2).
REQ-002 SHALL have port iClk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst  input  1  synchronous active-high reset.
REQ-004 SHALL have port iValid  input  1  request present.
REQ-005 SHALL have port iReady  output  1  request accepted this cycle when iValid=1.
REQ-006 SHALL have port iInstructionType  input  InstructionTypes  instruction class.
REQ-007 SHALL have port iInstructionSubType  input  InstructionSubTypes  operation within the class.
REQ-008 SHALL have ports iRd, iRs1 and iRs2  input  5 each  register indices.
REQ-009 SHALL have port iImm  input  32  signed immediate (byte offset for branches and jumps).
REQ-010 SHALL have port iPseudoLi  input  1  load-immediate pseudo-op: rd←iImm, all other fields ignored.
REQ-011 SHALL have port oValid  output  1  head word valid.
REQ-012 SHALL have port oReady  input  1  consumer takes the head word.
REQ-013 SHALL have port oInstruction  output  32  head word.
REQ-014 SHALL have port oCount  output  $clog2(FIFO_DEPTH)+1  buffer occupancy.
REQ-015 SHALL have port oError  output  1  sticky illegal-request flag.

Function
REQ-016 SHALL encode to standard RV32I formats: R, I, S, B, U and J field placement, funct3/funct7 per ISA; shifts use funct7 0000000, or 0100000 for the arithmetic variants; JUMP_LINK→JAL 1101111; JUMP_LINK_REG→JALR 1100111 with funct3 000.
REQ-017 SHALL flag a request as illegal when any of these holds: NULL subtype; I/S/JALR immediate outside −2048..2047; shamt >31; branch immediate odd or outside −4096..4094; JAL immediate odd or outside ±1 MiB; U immediate with iImm[11:0]≠0.
REQ-018 SHALL push NOP 0x00000013 for an illegal request and set oError, which stays set until reset.
REQ-019 SHALL assert iReady = (state==IDLE) && (oCount<FIFO_DEPTH), derived from registered state only, with no combinational path from oReady.
REQ-020 SHALL push on accept; the word is visible on oInstruction the next cycle when the buffer was empty (1-cycle latency).
REQ-021 SHALL pop when oValid && oReady; push and pop in the same cycle leave oCount unchanged.
REQ-022 SHALL keep output order equal to acceptance order.
REQ-023 SHALL drive oInstruction to 0x00000013 when the buffer is empty.
REQ-024 SHALL, for iPseudoLi with −2048≤iImm≤2047, emit one word ADDI rd,x0,iImm.
REQ-025 SHALL, for any other iPseudoLi value, emit LUI rd,(iImm+0x800)>>12 on accept, latch rd and iImm[11:0], and enter state SECOND.
REQ-026 SHALL, in SECOND, push ADDI rd,rd,imm[11:0] on the first cycle with oCount<FIFO_DEPTH, then return to IDLE; iReady=0 throughout SECOND.
REQ-027 SHALL have exactly two states, IDLE and SECOND.
REQ-028 SHALL wrap the buffer pointers modulo FIFO_DEPTH.
REQ-029 SHALL never overwrite a stored word or emit an unwritten word, whether full or empty.

Reset
REQ-030 SHALL, while iRst=1 at a clock edge, set state=IDLE, pointers=0, oCount=0, oValid=0, oError=0 and oInstruction=0x00000013.
REQ-031 SHALL hold iReady=0 during the iRst cycle and set iReady=1 on the first cycle after iRst.
REQ-032 SHALL, on a reset while in SECOND, discard the pending ADDI and all buffered words.

Structure
REQ-033 SHALL import InstructionTypes and InstructionSubTypes from the shared ControlTypeDefs package.
REQ-034 SHALL add to ControlTypeDefs the opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111) and NOP_WORD=32'h00000013.
REQ-035 SHALL place the buffer in one sub-module, instruction_fifo, parameterised by depth; the encode logic and state machine stay in instruction_encode.

Verification
REQ-036 SHALL verify: R ADD rd=3 rs1=1 rs2=2 → 0x002081B3 the next cycle, oCount=1.
REQ-037 SHALL verify: S SW rs1=1 rs2=2 iImm=−4 → 0xFE20AE23.
REQ-038 SHALL verify: LI rd=5 iImm=0x12345678 → 0x123452B7 then 0x67828293 on consecutive cycles (oReady=1), iReady low for one cycle; LI rd=5 iImm=0x00000FFF → 0x000012B7 then 0xFFF28293.
REQ-039 SHALL verify: BEQ iImm=3 → 0x00000013 and oError=1, still 1 after ten further legal requests.
REQ-040 SHALL verify: oReady=0 with 4 accepted requests → oCount=4, iReady=0, 5th request held; then oReady=1 → 4 words drain in order, one per cycle, and the 5th is accepted the cycle after the first pop.
REQ-041 SHALL verify: iRst asserted during SECOND → next cycle oValid=0, oCount=0, iReady=1, and no ADDI is ever emitted.
